// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / divide unit with architectural HI/LO.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start, op       : begin op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU) when idle
//   A, B            : multiplicand/dividend, multiplier/divisor (captured at start)
//   cancel          : abort in-flight operation; suppresses a start in IDLE
//   we_hi, we_lo    : MTHI/MTLO strobes, wdata is the write data
//   busy            : operation in progress
//   HI, LO          : architectural HI/LO registers
// Build option: define MULDIV_DIV_EN to include DIV/DIVU; otherwise op 1x starts are ignored.
module muldiv_unit #(
  parameter logic [31:0] HILO_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL} state_t;
`endif

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] mcand;     // multiplicand magnitude, or divisor magnitude
  logic [63:0] p;         // MUL: {accumulator, multiplier}; DIV: {remainder, quotient/dividend}
  logic        neg_res;

  logic        start_ok;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] mul_res;

`ifdef MULDIV_DIV_EN
  logic        neg_rem;
  logic        div0;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [31:0] div_r;
  logic [31:0] div_q;
  logic [31:0] quo;
  logic [31:0] rem;

  assign start_ok = start && !cancel;
`else
  assign start_ok = start && !cancel && !op[1];
`endif

  assign busy = (state != IDLE);

  always_comb begin
    a_neg    = !op[0] && A[31];
    b_neg    = !op[0] && B[31];
    a_mag    = a_neg ? -A : A;
    b_mag    = b_neg ? -B : B;
    mul_sum  = {1'b0, p[63:32]} + {1'b0, (p[0] ? mcand : 32'h0)};
    mul_next = {mul_sum, p[31:1]};
    mul_res  = neg_res ? -mul_next : mul_next;
`ifdef MULDIV_DIV_EN
    div_shift = {p[63:32], p[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, mcand};
    div_ge    = !div_diff[33];
    div_r     = div_ge ? div_diff[31:0] : div_shift[31:0];
    div_q     = {p[30:0], div_ge};
    // With a zero divisor the remainder path naturally ends at |A|, so only LO needs forcing.
    quo       = div0 ? '1 : (neg_res ? -div_q : div_q);
    rem       = neg_rem ? -div_r : div_r;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      HI      <= HILO_RST;
      LO      <= HILO_RST;
      cnt     <= '0;
      mcand   <= '0;
      p       <= '0;
      neg_res <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem <= 1'b0;
      div0    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            cnt     <= '0;
            neg_res <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
            if (op[1]) begin
              state   <= DIV;
              mcand   <= b_mag;
              p       <= {32'h0, a_mag};
              neg_rem <= a_neg;
              div0    <= (B == '0);
            end else
`endif
            begin
              state <= MUL;
              mcand <= a_mag;
              p     <= {32'h0, b_mag};
            end
          end else begin
            if (we_hi) HI <= wdata;
            if (we_lo) LO <= wdata;
          end
        end
        MUL: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            p   <= mul_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              HI    <= mul_res[63:32];
              LO    <= mul_res[31:0];
              state <= IDLE;
            end
          end
        end
`ifdef MULDIV_DIV_EN
        DIV: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            p   <= {div_r, div_q};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              HI    <= rem;
              LO    <= quo;
              state <= IDLE;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: HILO_RST, default 32'h0000_0000, reset value of HI and LO.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 start  in  1  one-cycle request to begin the operation selected by op.
REQ-006 op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 A  in  32  multiplicand/dividend (ID/EX rs value).
REQ-008 B  in  32  multiplier/divisor (ID/EX rt value).
REQ-009 cancel  in  1  pipeline flush; aborts the operation in progress.
REQ-010 we_hi, we_lo  in  1 each  MTHI/MTLO write strobes.
REQ-011 wdata  in  32  MTHI/MTLO data.
REQ-012 busy  out  1  high while an operation is in progress; EX/MEM stalls MFHI/MFLO/new muldiv while high.
REQ-013 HI, LO  out  32 each  architectural HI/LO registers, driven directly from flops.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, DIV; busy = (state != IDLE).
REQ-015 In IDLE, start SHALL latch A, B and op at the edge and enter MUL (op 0x) or DIV (op 1x); start SHALL be ignored in MUL/DIV.
REQ-016 Each operation SHALL take exactly 32 iteration cycles: busy high in cycles 1..32 after the start edge; HI/LO updated and busy low at edge 33.
REQ-017 Changes to A, B and op after the start edge SHALL have no effect on the result.
REQ-018 MULT SHALL produce the 64-bit two's-complement product {HI,LO}; MULTU the unsigned product.
REQ-019 Multiply SHALL be iterative shift-add on magnitudes with final conditional negation for MULT.
REQ-020 DIV/DIVU SHALL be iterative restoring division: LO = quotient truncated toward zero, HI = remainder carrying the sign of the dividend (DIV).
REQ-021 Divide by zero SHALL still take 32 cycles and yield LO = 32'hFFFF_FFFF, HI = A.
REQ-022 DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL yield LO = 32'h8000_0000, HI = 0.
REQ-023 HI/LO SHALL hold their previous values during cycles 1..32.
REQ-024 cancel while busy SHALL return to IDLE at that edge, leaving HI/LO unchanged; cancel SHALL take priority over completion in cycle 32.
REQ-025 cancel in IDLE SHALL suppress a simultaneous start.
REQ-026 we_hi/we_lo in IDLE with start low SHALL write wdata into HI/LO at that edge; both asserted SHALL write both.
REQ-027 we_hi/we_lo SHALL be ignored while busy or when start is accepted in the same cycle.

Reset
REQ-028 reset SHALL have priority over all inputs: state = IDLE, busy = 0, HI = LO = HILO_RST, iteration counter and operand registers cleared.
REQ-029 reset asserted mid-operation SHALL abort it; no result SHALL be written afterwards.

Configuration
REQ-030 Macro MULDIV_DIV_EN defined: DIV/DIVU supported as specified.
REQ-031 Macro MULDIV_DIV_EN undefined: DIV state and divider datapath SHALL be absent; start with op 1x SHALL be ignored (busy stays 0, HI/LO unchanged); multiply unchanged.

Verification
REQ-032 MULTU A=32'hFFFF_FFFF, B=32'h0000_0002 -> busy high 32 cycles, then HI=1, LO=32'hFFFF_FFFE.
REQ-033 MULT A=32'h3FF9_8732, B=32'hFFFF_FF00 (-256) -> HI=32'hFFFF_FFC0, LO=32'h0678_CE00; A/B toggled during busy do not alter the result.
REQ-034 DIV A=-7 (32'hFFFF_FFF9), B=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; DIVU A=5, B=0 -> LO=32'hFFFF_FFFF, HI=5.
REQ-035 we_hi with wdata=32'h1234_5678 in IDLE -> HI=32'h1234_5678; we_lo during busy -> LO unchanged; second start during busy ignored.
REQ-036 cancel at cycle 10 of MULT -> busy low next cycle, HI/LO keep prior values; reset at cycle 20 -> HI=LO=HILO_RST, busy=0, no later update.
REQ-037 Without MULDIV_DIV_EN: start with op=10 -> busy stays 0, HI/LO unchanged.
